// File: rtl/shifter_pkg.sv
// Shared constants and FSM encoding for the shifter arbiter and the Shifter it wraps.
package shifter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_SRA = 6'b000011;

    // Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/shifter_arbiter_if.sv
// One requester channel: a request (operand + shift amount) and its response.
interface shifter_arbiter_if;
    import shifter_pkg::*;

    // Both directions use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the sender holds its payload stable while
    // valid is high and ready is low, and may drop valid before the transfer.
    logic               req_valid;
    logic               req_ready;
    logic [DATA_W-1:0]  req_data;
    logic [SHAMT_W-1:0] req_shamt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;

    modport master (
        output req_valid, req_data, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/Shifter.sv
// Combinational 32-bit barrel shifter selected by a MIPS-style function code.
module Shifter
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0]  dataA,
    input  logic [SHAMT_W-1:0] dataB,
    input  logic [5:0]         Signal,
    input  logic               reset,
    output logic [DATA_W-1:0]  dataOut
);

    always_comb begin
        dataOut = '0;
        if (!reset) begin
            case (Signal)
                FUNCT_SLL: dataOut = dataA << dataB;
                FUNCT_SRL: dataOut = dataA >> dataB;
                FUNCT_SRA: dataOut = DATA_W'($signed(dataA) >>> dataB);
                default:   dataOut = '0;
            endcase
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin sharing of one logical-right Shifter between the ALU issue path (ch0)
// and the multiply/divide sequencer (ch1); one operation in flight at a time.
module shifter_arbiter
    import shifter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    shifter_arbiter_if.slave   ch0,
    shifter_arbiter_if.slave   ch1,
    output logic               busy,
    output state_t             dbgState
);

    state_t              state;
    state_t              stateNext;
    logic                rrPtr;
    logic                owner;
    logic [DATA_W-1:0]   opData;
    logic [SHAMT_W-1:0]  opShamt;
    logic [DATA_W-1:0]   resultReg;
    logic [DATA_W-1:0]   shiftOut;
    logic                anyValid;
    logic                grant;
    logic                ownerRspReady;

    assign anyValid      = ch0.req_valid | ch1.req_valid;
    // Contention goes to rrPtr; otherwise the lone valid requester wins.
    assign grant         = (ch0.req_valid & ch1.req_valid) ? rrPtr : ch1.req_valid;
    assign ownerRspReady = owner ? ch1.rsp_ready : ch0.rsp_ready;

    Shifter u_shifter (
        .dataA   (opData),
        .dataB   (opShamt),
        .Signal  (FUNCT_SRL),
        .reset   (reset),
        .dataOut (shiftOut)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = IDLE;
        case (state)
            IDLE:    stateNext = anyValid ? EXEC : IDLE;
            EXEC:    stateNext = RESP;
            RESP:    stateNext = ownerRspReady ? IDLE : RESP;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ch0.req_ready = 1'b0;
        ch1.req_ready = 1'b0;
        ch0.rsp_valid = 1'b0;
        ch1.rsp_valid = 1'b0;
        ch0.rsp_data  = '0;
        ch1.rsp_data  = '0;
        busy          = (state != IDLE);
        if (state == IDLE) begin
            ch0.req_ready = anyValid & ~grant;
            ch1.req_ready = anyValid & grant;
        end
        if (state == RESP) begin
            ch0.rsp_valid = ~owner;
            ch1.rsp_valid = owner;
            ch0.rsp_data  = owner ? '0 : resultReg;
            ch1.rsp_data  = owner ? resultReg : '0;
        end
    end

    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr     <= 1'b0;
            owner     <= 1'b0;
            opData    <= '0;
            opShamt   <= '0;
            resultReg <= '0;
        end else begin
            if (state == IDLE && anyValid) begin
                owner   <= grant;
                opData  <= grant ? ch1.req_data  : ch0.req_data;
                opShamt <= grant ? ch1.req_shamt : ch0.req_shamt;
            end
            if (state == EXEC) resultReg <= shiftOut;
            // The requester just served loses priority on the next contention.
            if (state == RESP && ownerRspReady) rrPtr <= ~owner;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed plus randomized checks of the shifter arbiter against a queue-based model.
module tb_shifter_arbiter;
    import shifter_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   busy;
    state_t dbgState;

    shifter_arbiter_if ch0 ();
    shifter_arbiter_if ch1 ();

    shifter_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .ch0      (ch0),
        .ch1      (ch1),
        .busy     (busy),
        .dbgState (dbgState)
    );

    always #5 clk = ~clk;

    logic        reqValid [2];
    logic [31:0] reqData  [2];
    logic [4:0]  reqShamt [2];
    logic        rspReady [2];
    logic        reqReady [2];
    logic        rspValid [2];
    logic [31:0] rspData  [2];

    assign ch0.req_valid = reqValid[0];
    assign ch0.req_data  = reqData[0];
    assign ch0.req_shamt = reqShamt[0];
    assign ch0.rsp_ready = rspReady[0];
    assign ch1.req_valid = reqValid[1];
    assign ch1.req_data  = reqData[1];
    assign ch1.req_shamt = reqShamt[1];
    assign ch1.rsp_ready = rspReady[1];
    assign reqReady[0]   = ch0.req_ready;
    assign reqReady[1]   = ch1.req_ready;
    assign rspValid[0]   = ch0.rsp_valid;
    assign rspValid[1]   = ch1.rsp_valid;
    assign rspData[0]    = ch0.rsp_data;
    assign rspData[1]    = ch1.rsp_data;

    int          nChecks  = 0;
    int          nFails   = 0;
    int          modelPtr = 0;
    logic [31:0] exp_q[$];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pair(input logic b1, input logic b0);
        return {30'd0, b1, b0};
    endfunction

    // Logical right shift as an unsigned division by a power of two.
    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s);
        longint unsigned q;
        q = longint'(d) / (longint'(1) << s);
        return q[31:0];
    endfunction

    function automatic int expWinner();
        if (reqValid[0] && reqValid[1]) return modelPtr;
        return reqValid[1] ? 1 : 0;
    endfunction

    // Runs one full transaction for requester 'who' starting from IDLE.
    task automatic complete(input int who, input int holdoff, input bit dropValid, input bit raiseOther);
        int          other;
        int          waited;
        logic [31:0] expData;
        other  = 1 - who;
        waited = 0;
        settle();
        while (!reqReady[0] && !reqReady[1] && waited < 8) begin
            step();
            settle();
            waited++;
        end
        chk("grant", pair(reqReady[1], reqReady[0]), (who == 1) ? 32'd2 : 32'd1);
        exp_q.push_back(refShift(reqData[who], reqShamt[who]));
        rspReady[who] = (holdoff == 0);
        step();
        if (dropValid)  reqValid[who]   = 1'b0;
        if (raiseOther) reqValid[other] = 1'b1;
        settle();
        chk("exec_busy",  32'(busy), 32'd1);
        chk("exec_ready", pair(reqReady[1], reqReady[0]), 32'd0);
        chk("exec_rsp",   pair(rspValid[1], rspValid[0]), 32'd0);
        step();
        settle();
        expData = exp_q[0];
        chk("rsp_valid", pair(rspValid[1], rspValid[0]), (who == 1) ? 32'd2 : 32'd1);
        chk("rsp_data",  rspData[who], expData);
        chk("rsp_ready_blocked", pair(reqReady[1], reqReady[0]), 32'd0);
        for (int i = 1; i < holdoff; i++) begin
            step();
            settle();
            chk("stall_valid", pair(rspValid[1], rspValid[0]), (who == 1) ? 32'd2 : 32'd1);
            chk("stall_data",  rspData[who], expData);
            chk("stall_ready", pair(reqReady[1], reqReady[0]), 32'd0);
        end
        rspReady[who] = 1'b1;
        step();
        settle();
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_rsp",  pair(rspValid[1], rspValid[0]), 32'd0);
        void'(exp_q.pop_front());
        modelPtr      = other;
        rspReady[who] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pattern;
        int winner;
        int holdoff;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0;
            reqData[i]  = '0;
            reqShamt[i] = '0;
            rspReady[i] = 1'b0;
        end

        // Reset held for two cycles.
        step();
        step();
        settle();
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_state", 32'(dbgState), 32'(IDLE));
        chk("reset_ready", pair(reqReady[1], reqReady[0]), 32'd0);
        chk("reset_rsp",   pair(rspValid[1], rspValid[0]), 32'd0);
        chk("reset_data0", rspData[0], 32'd0);
        chk("reset_data1", rspData[1], 32'd0);
        reset = 1'b0;
        modelPtr = 0;

        // Both requesters valid and held across two operations.
        step();
        reqValid[0] = 1'b1; reqData[0] = 32'h1234_5678; reqShamt[0] = 5'd8;
        reqValid[1] = 1'b1; reqData[1] = 32'hCAFE_F00D; reqShamt[1] = 5'd16;
        complete(0, 0, 1'b0, 1'b0);
        complete(1, 0, 1'b1, 1'b0);
        reqValid[0] = 1'b0;
        step();
        reqValid[0] = 1'b1; reqValid[1] = 1'b1;
        complete(0, 0, 1'b1, 1'b0);
        reqValid[1] = 1'b0;

        // Single requester 0, ready already high.
        step();
        reqValid[0] = 1'b1; reqData[0] = 32'hF000_000F; reqShamt[0] = 5'd4;
        chk("model_f00f", refShift(reqData[0], reqShamt[0]), 32'h0F00_0000);
        complete(0, 0, 1'b1, 1'b0);

        // Shift-amount boundaries.
        step();
        reqValid[1] = 1'b1; reqData[1] = 32'hDEAD_BEEF; reqShamt[1] = 5'd0;
        complete(1, 0, 1'b1, 1'b0);
        step();
        reqValid[0] = 1'b1; reqData[0] = 32'h8000_0000; reqShamt[0] = 5'd31;
        complete(0, 0, 1'b1, 1'b0);

        // Requester 1 response held off 5 cycles while requester 0 waits.
        step();
        reqValid[1] = 1'b1; reqData[1] = 32'h0F0F_1234; reqShamt[1] = 5'd12;
        reqData[0]  = 32'h7777_AAAA; reqShamt[0] = 5'd3;
        complete(1, 5, 1'b1, 1'b1);
        complete(0, 0, 1'b1, 1'b0);

        // Reset during EXEC drops the transaction.
        step();
        reqValid[0] = 1'b1; reqData[0] = 32'hFFFF_FFFF; reqShamt[0] = 5'd1;
        rspReady[0] = 1'b1;
        settle();
        chk("rst_exec_grant", pair(reqReady[1], reqReady[0]), 32'd1);
        step();
        reqValid[0] = 1'b0;
        reset = 1'b1;
        settle();
        chk("rst_exec_busy", 32'(busy), 32'd1);
        step();
        reset = 1'b0;
        modelPtr = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_no_rsp",  pair(rspValid[1], rspValid[0]), 32'd0);
            chk("rst_idle",    32'(dbgState), 32'(IDLE));
            step();
        end
        rspReady[0] = 1'b0;
        reqValid[1] = 1'b1; reqData[1] = 32'h0000_FF00; reqShamt[1] = 5'd8;
        complete(1, 0, 1'b1, 1'b0);

        // Randomized mix of requesters, operands and response hold-offs.
        for (int n = 0; n < 24; n++) begin
            step();
            pattern = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++) begin
                reqValid[i] = pattern[i];
                reqData[i]  = $urandom;
                reqShamt[i] = 5'($urandom_range(0, 31));
            end
            holdoff = $urandom_range(0, 3);
            winner  = expWinner();
            complete(winner, holdoff, 1'b1, 1'b0);
            reqValid[0] = 1'b0;
            reqValid[1] = 1'b0;
        end

        step();
        settle();
        chk("final_idle", 32'(dbgState), 32'(IDLE));
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
